// File: rtl/bsg_dff_gatestack_sched.sv
// Round-robin scheduler that writes into a clock-gated flop stack: it presents the data,
// pulses a glitch-free per-bit gate for pulse_cycles_p cycles, then signals completion.
module bsg_dff_gatestack_sched #(
  parameter int width_p        = 32,
  parameter int pulse_cycles_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               r0_v_i,
  input  logic [width_p-1:0] r0_data_i,
  input  logic [width_p-1:0] r0_mask_i,
  output logic               r0_ready_o,
  input  logic               r1_v_i,
  input  logic [width_p-1:0] r1_data_i,
  input  logic [width_p-1:0] r1_mask_i,
  output logic               r1_ready_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] gate_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               done_id_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [3:0] cnt_init_lp = 4'(pulse_cycles_p - 1);

  state_e             state_q, state_d;
  logic [width_p-1:0] data_q, data_d;
  logic [width_p-1:0] mask_q, mask_d;
  logic [width_p-1:0] gate_q, gate_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               id_q, id_d;
  logic               ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;

  logic               idle;
  logic               grant0, grant1;
  logic               accept;
  logic [width_p-1:0] win_data, win_mask;

  // ptr_q names the favoured requester when both are valid (0 = r0).
  assign idle     = (state_q == IDLE);
  assign grant1   = r1_v_i & (~r0_v_i | ptr_q);
  assign grant0   = r0_v_i & ~grant1;
  assign accept   = idle & (r0_v_i | r1_v_i);
  assign win_data = grant1 ? r1_data_i : r0_data_i;
  assign win_mask = grant1 ? r1_mask_i : r0_mask_i;

  assign r0_ready_o = idle & grant0;
  assign r1_ready_o = idle & grant1;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = win_data;
          mask_d = win_mask;
          id_d   = grant1;
          ptr_d  = ~grant1;
          if (|win_mask) begin
            state_d = SETUP;
          end else begin
            state_d   = HOLD;
            done_d    = 1'b1;
            done_id_d = grant1;
          end
        end
      end
      SETUP: begin
        state_d = PULSE;
        gate_d  = mask_q;
        cnt_d   = cnt_init_lp;
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d   = HOLD;
          gate_d    = '0;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gate_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      gate_q    <= '0;
      cnt_q     <= 4'd0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  // The gate leaves straight from its flops so the stack clocks never see a glitch.
  assign gate_o    = gate_q;
  assign data_o    = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;

endmodule

// File: doc/bsg_dff_gatestack_sched.md
BSG_DFF_GATESTACK_SCHED -- requirements
Module: bsg_dff_gatestack_sched

Interface
REQ-001 SHALL have parameter width_p, default 32, meaning the bit count of the driven gatestack.
REQ-002 SHALL have parameter pulse_cycles_p, default 1, legal 1..15, meaning the gate-high duration in clk_i cycles.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state advances on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports r0_v_i and r1_v_i, input, 1 bit each: requester 0/1 write request valid.
REQ-006 SHALL have ports r0_data_i and r1_data_i, input, width_p each: requester write data.
REQ-007 SHALL have ports r0_mask_i and r1_mask_i, input, width_p each: requester per-bit write select.
REQ-008 SHALL have ports r0_ready_o and r1_ready_o, output, 1 bit each: the request is accepted when v and ready are both high.
REQ-009 SHALL have port data_o, output, width_p: data to the gatestack data inputs.
REQ-010 SHALL have port gate_o, output, width_p: per-bit gate (clock) to the gatestack clock inputs.
REQ-011 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port done_id_o, output, 1 bit: requester index of the completing write, valid while done_o is high.

Function
REQ-014 SHALL implement the states IDLE, SETUP, PULSE and HOLD.
REQ-015 SHALL drive gate_o directly from flops, with no combinational logic after the registers, so the gate has no glitches.
REQ-016 In IDLE, ready SHALL be given to one requester only: the winner of round-robin arbitration among the valid requesters.
REQ-017 When both requesters are valid, the requester not granted last SHALL win; after reset the priority pointer SHALL favour r0.
REQ-018 The priority pointer SHALL update only on an accepted handshake.
REQ-019 Each ready SHALL be low in every state except IDLE.
REQ-020 On acceptance (cycle T), the block SHALL latch the winner's data, mask and id.
REQ-021 On acceptance with a non-zero mask, the next state SHALL be SETUP.
REQ-022 On acceptance with a zero mask, the next state SHALL be HOLD, skipping SETUP and PULSE.
REQ-023 In SETUP (T+1), data_o SHALL equal the latched data and gate_o SHALL be 0.
REQ-024 In PULSE (T+2 .. T+1+pulse_cycles_p), gate_o SHALL equal the latched mask and data_o SHALL be held.
REQ-025 A 4-bit down-counter SHALL time PULSE.
REQ-026 In HOLD (T+2+pulse_cycles_p for a non-zero mask, T+1 for a zero mask), gate_o SHALL be 0, data_o SHALL be held, and done_o and done_id_o SHALL be asserted.
REQ-027 After HOLD the next state SHALL be IDLE.
REQ-028 data_o SHALL retain the last written data while the block is in IDLE.
REQ-029 A new acceptance SHALL be possible at the earliest in the cycle after HOLD, giving a throughput of one write per pulse_cycles_p+3 cycles.
REQ-030 A requester dropping v_i before it is granted SHALL have no effect; requests have no pending memory.
REQ-031 Mask bits not selected SHALL never pulse on gate_o.

Reset
REQ-032 While reset_n_i is low, the block SHALL immediately and asynchronously force the state to IDLE, gate_o to 0, data_o to 0, busy_o to 0, done_o to 0, done_id_o to 0 and the pointer to r0.
REQ-033 Reset asserted during PULSE SHALL drop gate_o to 0 without waiting for a clock edge, and the aborted write SHALL produce no done_o.
REQ-034 After reset_n_i deasserts, the first clk_i edge SHALL evaluate the IDLE arbitration normally.

Verification
REQ-035 Single write: pulse_cycles_p=1; r0_v_i=1, r0_data_i=32'hA5A5_0F0F, r0_mask_i=32'hFFFF_FFFF at T -> SETUP at T+1 with gate_o=0 and data_o=32'hA5A5_0F0F; gate_o=32'hFFFF_FFFF at T+2 only; done_o=1 with done_id_o=0 at T+3; ready high again at T+4.
REQ-036 Contention: r0 and r1 both valid continuously after reset -> grants in the order r0, r1, r0, r1; each ready is high for only one cycle per grant.
REQ-037 Pulse width: pulse_cycles_p=4, mask 32'h0000_0011 -> gate_o=32'h0000_0011 for exactly 4 consecutive cycles and all other bits stay 0 throughout.
REQ-038 Zero mask: r1 with mask 0 at T -> gate_o stays 0; done_o=1 with done_id_o=1 at T+1; IDLE at T+2.
REQ-039 Reset mid-pulse: pulse_cycles_p=3; reset_n_i low during the 2nd PULSE cycle -> gate_o=0 and data_o=0 with no clock edge; no done_o; the next write after release is granted to r0.
